// File: rtl/sobel_bist_controller_pkg.sv
// sobel_bist_controller_pkg: shared widths, BIST FSM states and LFSR taps for the gray/Sobel self-test.
package sobel_bist_controller_pkg;

    localparam int PIXEL_WIDTH_IN         = 24;
    localparam int MAX_PIXEL_BITS         = 24;
    localparam int CNT_WIDTH_DEFAULT      = 16;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    // Fibonacci taps 24,23,22,17 expressed as bit positions 23,22,21,16
    localparam logic [PIXEL_WIDTH_IN-1:0] LFSR_TAPS = 24'hE1_0000;

    typedef enum logic [2:0] {
        BIST_IDLE,
        BIST_CLEAR,
        BIST_RUN,
        BIST_DRAIN,
        BIST_CHECK,
        BIST_DONE
    } bist_state_e;

    function automatic logic [PIXEL_WIDTH_IN-1:0] lfsr_step(input logic [PIXEL_WIDTH_IN-1:0] v);
        return {v[PIXEL_WIDTH_IN-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sobel_bist_controller_lfsr.sv
// bist_lfsr: stimulus LFSR with seed load (zero seed forced to 1) and per-transfer advance.
module bist_lfsr
    import sobel_bist_controller_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic                      load_i,
    input  logic [PIXEL_WIDTH_IN-1:0] seed_i,
    input  logic                      advance_i,
    output logic [PIXEL_WIDTH_IN-1:0] value_o
);

    localparam logic [PIXEL_WIDTH_IN-1:0] LFSR_ONE = PIXEL_WIDTH_IN'(1);

    logic [PIXEL_WIDTH_IN-1:0] lfsr_q, lfsr_d;

    // An all-zero state would lock the LFSR, so a zero seed becomes 1
    always_comb begin
        lfsr_d = load_i    ? ((seed_i == '0) ? LFSR_ONE : seed_i) :
                 advance_i ? lfsr_step(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) lfsr_q <= LFSR_ONE;
        else           lfsr_q <= lfsr_d;
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/sobel_bist_controller.sv
// sobel_bist_controller: drives LFSR stimulus into the pixel pipeline, sequences the signature
// analyzer, counts responses and checks the final signature against a golden value.
module sobel_bist_controller
    import sobel_bist_controller_pkg::*;
#(
    parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [CNT_WIDTH-1:0]      num_pixels_i,
    input  logic [PIXEL_WIDTH_IN-1:0] seed_i,
    input  logic [MAX_PIXEL_BITS-1:0] golden_i,
    output logic [PIXEL_WIDTH_IN-1:0] stim_data_o,
    output logic                      stim_valid_o,
    input  logic                      stim_ready_i,
    input  logic                      resp_valid_i,
    output logic                      sa_clear_o,
    output logic                      sa_en_o,
    input  logic [MAX_PIXEL_BITS-1:0] signature_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o
);

    localparam int                   IW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [IW-1:0]        IDLE_ONE = IW'(1);
    localparam logic [IW-1:0]        IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);

    bist_state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0]      num_q, num_d;
    logic [CNT_WIDTH-1:0]      sent_q, sent_d;
    logic [CNT_WIDTH-1:0]      recv_q, recv_d;
    logic [IW-1:0]             idle_q, idle_d;
    logic [MAX_PIXEL_BITS-1:0] golden_q, golden_d;
    logic                      pass_q, pass_d;
    logic                      timeout_q, timeout_d;
    logic [PIXEL_WIDTH_IN-1:0] lfsr_value;
    logic                      start_ok, accept, counted, in_run, in_sa_en;

    assign in_run   = (state_q == BIST_RUN);
    assign in_sa_en = in_run || (state_q == BIST_DRAIN);
    assign start_ok = start_i && !abort_i && ((state_q == BIST_IDLE) || (state_q == BIST_DONE));
    assign accept   = in_run && stim_ready_i;
    // recv saturates at the programmed count so surplus responses cannot wrap it
    assign counted  = resp_valid_i && in_sa_en && (recv_q != num_q);

    bist_lfsr u_lfsr (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .load_i    (start_ok),
        .seed_i    (seed_i),
        .advance_i (accept),
        .value_o   (lfsr_value)
    );

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        idle_d    = idle_q;
        golden_d  = golden_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        if (abort_i) begin
            state_d   = BIST_IDLE;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end else begin
            if (counted) recv_d = recv_q + CNT_ONE;
            unique case (state_q)
                BIST_IDLE, BIST_DONE: begin
                    if (start_i) begin
                        state_d   = BIST_CLEAR;
                        num_d     = num_pixels_i;
                        golden_d  = golden_i;
                        pass_d    = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                BIST_CLEAR: begin
                    sent_d  = '0;
                    recv_d  = '0;
                    idle_d  = '0;
                    state_d = (num_q == '0) ? BIST_CHECK : BIST_RUN;
                end
                BIST_RUN: begin
                    if (accept) sent_d = sent_q + CNT_ONE;
                    if (accept && (sent_q + CNT_ONE == num_q)) state_d = BIST_DRAIN;
                end
                BIST_DRAIN: begin
                    if (recv_q == num_q) begin
                        state_d = BIST_CHECK;
                    end else if (counted) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_MAX) begin
                        state_d   = BIST_DONE;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end else begin
                        idle_d = idle_q + IDLE_ONE;
                    end
                end
                BIST_CHECK: begin
                    // analyzer already absorbed the last response on the previous edge
                    pass_d  = (signature_i == golden_q);
                    state_d = BIST_DONE;
                end
                default: state_d = BIST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q   <= BIST_IDLE;
            num_q     <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
            idle_q    <= '0;
            golden_q  <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            idle_q    <= idle_d;
            golden_q  <= golden_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign stim_valid_o = in_run;
    assign stim_data_o  = in_run ? lfsr_value : '0;
    assign sa_clear_o   = (state_q == BIST_CLEAR);
    assign sa_en_o      = in_sa_en;
    assign busy_o       = (state_q == BIST_CLEAR) || in_sa_en || (state_q == BIST_CHECK);
    assign done_o       = (state_q == BIST_DONE);
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sobel_bist_controller.sv
// tb_sobel_bist_controller: echo-datapath stub plus behavioural analyzer around the BIST controller,
// checked against an arithmetic model of the stimulus stream and expected signature.
module tb_sobel_bist_controller;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        nreset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        stim_ready_i = 1'b1;
    logic        resp_valid_i;
    logic [15:0] num_pixels_i = '0;
    logic [23:0] seed_i = '0;
    logic [23:0] golden_i = '0;
    logic [23:0] signature_i;
    logic [23:0] stim_data_o;
    logic        stim_valid_o, sa_clear_o, sa_en_o, busy_o, done_o, pass_o, timeout_o;
    logic [7:0]  resp_data;
    int          accept_n;
    int          drop_idx = 0;

    int          n_pass = 0;
    int          n_total = 0;
    int          busy_cyc, clr_cyc, idle_run;
    bit          had_valid, done_seen;
    logic [23:0] acc_q[$];

    sobel_bist_controller #(.CNT_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk_i),
        .nreset_i     (nreset_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .num_pixels_i (num_pixels_i),
        .seed_i       (seed_i),
        .golden_i     (golden_i),
        .stim_data_o  (stim_data_o),
        .stim_valid_o (stim_valid_o),
        .stim_ready_i (stim_ready_i),
        .resp_valid_i (resp_valid_i),
        .sa_clear_o   (sa_clear_o),
        .sa_en_o      (sa_en_o),
        .signature_i  (signature_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] lfsr_model(input logic [23:0] x);
        int unsigned v;
        v = x;
        return 24'(((v * 2) % (1 << 24)) + ($countones(x & 24'hE10000) % 2));
    endfunction

    function automatic logic [23:0] misr_model(input logic [23:0] sig, input logic [7:0] b);
        return lfsr_model(sig) ^ {16'h0, b};
    endfunction

    function automatic logic [23:0] model_sig(input logic [23:0] sd, input int n, input int drop);
        logic [23:0] s, sig;
        s = (sd == 0) ? 24'h1 : sd;
        sig = '0;
        for (int i = 0; i < n; i++) begin
            if (i + 1 != drop) sig = misr_model(sig, s[7:0]);
            s = lfsr_model(s);
        end
        return sig;
    endfunction

    // datapath stub: echoes the low byte one cycle after each accepted stimulus
    always @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            resp_valid_i <= 1'b0;
            resp_data    <= '0;
            accept_n     <= 0;
        end else begin
            resp_valid_i <= stim_valid_o && stim_ready_i && (accept_n + 1 != drop_idx);
            resp_data    <= stim_data_o[7:0];
            if (sa_clear_o) accept_n <= 0;
            else if (stim_valid_o && stim_ready_i) accept_n <= accept_n + 1;
        end
    end

    always @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i)                    signature_i <= '0;
        else if (sa_clear_o)              signature_i <= '0;
        else if (sa_en_o && resp_valid_i) signature_i <= misr_model(signature_i, resp_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_stream(input string tag, input logic [23:0] sd, input int n);
        logic [23:0] s;
        int bad;
        s = (sd == 0) ? 24'h1 : sd;
        bad = 0;
        chk({tag, "_count"}, 32'(acc_q.size()), 32'(n));
        foreach (acc_q[i]) begin
            if (acc_q[i] !== s) bad++;
            s = lfsr_model(s);
        end
        chk({tag, "_data"}, 32'(bad), 32'd0);
    endtask

    task automatic run_test(input int n, input logic [23:0] sd, input logic [23:0] gd,
                            input int rmode, input bit poke_start);
        bit          prev_stall;
        logic [23:0] prev_data;
        acc_q.delete();
        busy_cyc = 0; clr_cyc = 0; idle_run = 0; had_valid = 0; done_seen = 0;
        prev_stall = 0; prev_data = '0;
        num_pixels_i = 16'(n); seed_i = sd; golden_i = gd; start_i = 1'b1; stim_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done_o) begin
                done_seen = 1;
                break;
            end
            if (busy_o) busy_cyc++;
            if (sa_clear_o) clr_cyc++;
            if (stim_valid_o) had_valid = 1;
            idle_run = resp_valid_i ? 0 : idle_run + 1;
            if (prev_stall) chk("stall_hold", {7'h0, stim_valid_o, stim_data_o}, {8'h1, prev_data});
            if (poke_start && c == 3) begin
                start_i = 1'b1;
                num_pixels_i = 16'(n + 7);
            end else start_i = 1'b0;
            if (rmode == 0)      stim_ready_i = 1'b1;
            else if (rmode == 1) stim_ready_i = ~stim_ready_i;
            else                 stim_ready_i = 1'($urandom_range(0, 1));
            if (stim_valid_o && stim_ready_i) acc_q.push_back(stim_data_o);
            prev_stall = stim_valid_o && !stim_ready_i;
            prev_data  = stim_data_o;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk("done_reached", 32'(done_seen), 32'd1);
    endtask

    task automatic start_and_wait_valid(input int n, input logic [23:0] sd);
        bit seen;
        seen = 0;
        num_pixels_i = 16'(n); seed_i = sd; golden_i = '0; stim_ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_i);
            seen = stim_valid_o;
        end
        chk("reach_run", 32'(seen), 32'd1);
    endtask

    initial begin
        logic [23:0] sd, g, sig_a;
        int n;
        bit bad;

        #12;
        chk("reset_outputs", {7'h0, stim_valid_o, sa_clear_o, sa_en_o, busy_o, done_o, pass_o, timeout_o},
            32'd0);
        chk("reset_stim_data", {8'h0, stim_data_o}, 32'd0);
        @(negedge clk_i);
        nreset_i = 1'b1;
        @(negedge clk_i);

        run_test(1, 24'h000001, 24'h000001, 0, 0);
        chk("t1_clear_pulses", 32'(clr_cyc), 32'd1);
        check_stream("t1_stream", 24'h000001, 1);
        chk("t1_flags", {29'h0, done_o, pass_o, timeout_o}, 32'b110);
        chk("t1_busy_cycles", 32'(busy_cyc), 32'd5);
        chk("t1_signature", {8'h0, signature_i}, {8'h0, model_sig(24'h1, 1, 0)});

        run_test(4, 24'h000000, 24'hFFFFFF, 0, 0);
        chk("t2_first_stim", {8'h0, (acc_q.size() > 0) ? acc_q[0] : 24'h0}, 32'h1);
        check_stream("t2_stream", 24'h0, 4);
        chk("t2_flags", {29'h0, done_o, pass_o, timeout_o}, 32'b100);

        sd = 24'h5A5A5A;
        g  = model_sig(sd, 8, 0);
        run_test(8, sd, g, 0, 0);
        sig_a = signature_i;
        chk("t3a_pass", 32'(pass_o), 32'd1);
        run_test(8, sd, g, 1, 0);
        check_stream("t3b_stream", sd, 8);
        chk("t3b_sig_vs_ready1", {8'h0, signature_i}, {8'h0, sig_a});
        chk("t3b_pass", 32'(pass_o), 32'd1);

        drop_idx = 3;
        sd = 24'h123456;
        run_test(3, sd, model_sig(sd, 3, 0), 0, 0);
        chk("t4_flags", {29'h0, done_o, pass_o, timeout_o}, 32'b101);
        chk("t4_idle_cycles", 32'(idle_run), 32'(TO));
        chk("t4_signature", {8'h0, signature_i}, {8'h0, model_sig(sd, 3, 3)});
        drop_idx = 0;

        run_test(0, 24'h000077, 24'h000000, 0, 0);
        chk("t5_no_valid", 32'(had_valid), 32'd0);
        chk("t5_busy_cycles", 32'(busy_cyc), 32'd2);
        chk("t5_clear_pulses", 32'(clr_cyc), 32'd1);
        chk("t5_flags", {29'h0, done_o, pass_o, timeout_o}, 32'b110);

        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_done_flags", {29'h0, done_o, pass_o, timeout_o}, 32'd0);

        start_and_wait_valid(40, 24'h000009);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_run", {28'h0, busy_o, stim_valid_o, sa_en_o, done_o}, 32'd0);

        start_and_wait_valid(40, 24'h0000AB);
        #2 nreset_i = 1'b0;
        #1;
        chk("async_reset_outputs", {7'h0, stim_valid_o, sa_clear_o, sa_en_o, busy_o, done_o, pass_o, timeout_o},
            32'd0);
        chk("async_reset_data", {8'h0, stim_data_o}, 32'd0);
        @(negedge clk_i);
        nreset_i = 1'b1;
        @(negedge clk_i);

        sd = 24'hC0FFEE;
        run_test(5, sd, model_sig(sd, 5, 0), 0, 0);
        check_stream("t8_stream", sd, 5);
        chk("t8_flags", {29'h0, done_o, pass_o, timeout_o}, 32'b110);

        for (int k = 0; k < 6; k++) begin
            n   = int'($urandom_range(1, 24));
            sd  = 24'($urandom);
            bad = 1'($urandom_range(0, 1));
            g   = model_sig(sd, n, 0) ^ {23'h0, bad};
            run_test(n, sd, g, 2, 1);
            check_stream("rand_stream", sd, n);
            chk("rand_signature", {8'h0, signature_i}, {8'h0, model_sig(sd, n, 0)});
            chk("rand_flags", {29'h0, done_o, pass_o, timeout_o}, {29'h0, 1'b1, !bad, 1'b0});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
